shared_mac_array: RTL and testbench
===================================

SHARED_MAC_ARRAY -- requirements
Module: shared_mac_array

Interface
REQ-001 Parameter N_MAC, default 16: number of MAC lanes.
REQ-002 Parameter N_SRC, default 3: number of layer clients sharing the array.
REQ-003 Parameter A_W, default 16: signed feature operand width.
REQ-004 Parameter B_W, default 8: signed weight operand width.
REQ-005 Parameter ACC_W, default 23: signed accumulator width per lane.
REQ-006 Parameter LEN_W, default 10: job length field width.
REQ-007 clk  in  1  single clock; all state updates on rising edge.
REQ-008 rst_n  in  1  asynchronous, active-low reset.
REQ-009 req  in  N_SRC  per-client job request, level.
REQ-010 req_len  in  N_SRC*LEN_W  per-client beat count; client i uses bits [i*LEN_W +: LEN_W].
REQ-011 gnt  out  N_SRC  one-hot owner of the array.
REQ-012 op_valid  in  1  operand beat valid from the owner.
REQ-013 op_a  in  A_W  feature, broadcast to all lanes.
REQ-014 op_b  in  N_MAC*B_W  weights; lane k uses bits [k*B_W +: B_W].
REQ-015 op_ready  out  1  array accepts a beat.
REQ-016 res_valid  out  1  one-cycle result pulse.
REQ-017 res_src  out  max(1,clog2(N_SRC))  index of the job owner.
REQ-018 res_data  out  N_MAC*ACC_W  lane k accumulator at [k*ACC_W +: ACC_W].
REQ-019 res_ovf  out  1  any lane saturated during the job.
REQ-020 busy  out  1  high in every state except IDLE.

Function
REQ-021 The FSM SHALL have the states IDLE, RUN, DRAIN and DONE.
REQ-022 In IDLE with any req bit high, the block SHALL grant one client round-robin, starting the search at last_granted+1, and move to RUN next cycle.
REQ-023 On grant, the block SHALL latch that client's req_len (0 treated as 1) and clear all accumulators and the ovf flag.
REQ-024 gnt SHALL stay one-hot and constant from entry to RUN until the cycle after res_valid; it is zero otherwise.
REQ-025 op_ready SHALL be 1 only in RUN; a beat is accepted when op_valid and op_ready are both high; bubbles are allowed.
REQ-026 Stage 1 SHALL register accepted operands; stage 2 SHALL compute acc_k += op_a*op_b_k (signed, full-width product sign-extended to ACC_W).
REQ-027 Accumulation SHALL saturate to the signed ACC_W max/min; any saturation sets res_ovf (sticky per job).
REQ-028 The cycle the len-th beat is accepted, op_ready SHALL drop next cycle; the FSM enters DRAIN for 2 cycles, then DONE.
REQ-029 DONE SHALL last 1 cycle with res_valid=1, res_src=owner index; then the FSM returns to IDLE.
REQ-030 Latency: last beat accepted at cycle t gives res_valid at t+3.
REQ-031 res_data/res_ovf SHALL hold their values until the next grant clears them.
REQ-032 Deasserting req mid-job SHALL NOT abort it; the job runs to DONE.
REQ-033 A req held high during DONE SHALL be arbitrated in the following IDLE cycle (minimum 1 idle cycle between jobs).
REQ-034 op_valid outside RUN SHALL be ignored with no accumulator change.

Reset
REQ-035 When rst_n is low, the block SHALL asynchronously force: state IDLE; gnt, op_ready, res_valid, res_ovf, busy to 0; res_src, res_data to 0; and the round-robin pointer so that client 0 has the highest priority.
REQ-036 Reset asserted mid-job SHALL discard the job with no res_valid pulse; operation resumes on the first clock after release.

Verification
REQ-037 req=001, len=3, beats a=2,-3,4 with all b=5 -> gnt=001, res_valid 3 cycles after the 3rd beat, every lane=15, res_ovf=0, res_src=0.
REQ-038 req=111 held over three jobs -> grants 001, 010, 100 in order, each followed by exactly one res_valid with matching res_src.
REQ-039 a=32767, b=127, len=4 (ACC_W=23) -> lane saturates at 4194303, res_ovf=1; a=-32768, b=127 -> -4194304.
REQ-040 len=2 beats with 3 idle bubbles between them -> result equals the no-bubble result; op_ready low only after the 2nd beat.
REQ-041 rst_n pulsed low after the 2nd of 5 beats -> all outputs 0 immediately, no res_valid; the next job's result is uncontaminated.
REQ-042 req_len=0 -> exactly one beat accepted, res_valid at t+3.

Source files
------------

// File: rtl/shared_mac_array.sv
// Shared MAC array: N_SRC clients take turns (round-robin) owning N_MAC
// saturating multiply-accumulate lanes. A job streams len operand beats,
// the feature operand is broadcast to all lanes and every lane has its own weight.
// The result is reported with a one-cycle pulse and then held until the next grant.
module shared_mac_array #(
  parameter int N_MAC = 16,
  parameter int N_SRC = 3,
  parameter int A_W   = 16,
  parameter int B_W   = 8,
  parameter int ACC_W = 23,
  parameter int LEN_W = 10,
  localparam int SRC_W = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_SRC-1:0]         req,
  input  logic [N_SRC*LEN_W-1:0]   req_len,
  output logic [N_SRC-1:0]         gnt,
  input  logic                     op_valid,
  input  logic [A_W-1:0]           op_a,
  input  logic [N_MAC*B_W-1:0]     op_b,
  output logic                     op_ready,
  output logic                     res_valid,
  output logic [SRC_W-1:0]         res_src,
  output logic [N_MAC*ACC_W-1:0]   res_data,
  output logic                     res_ovf,
  output logic                     busy
);

  localparam int P_W   = A_W + B_W;
  localparam int SUM_W = ((P_W > ACC_W) ? P_W : ACC_W) + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic signed [SUM_W-1:0] SUM_MAX = {{(SUM_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SUM_MIN = {{(SUM_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};

  // Saturating add of a full-width product into an accumulator; MSB of the result flags saturation.
  function automatic logic [ACC_W:0] sat_acc(input logic signed [ACC_W-1:0] acc,
                                             input logic signed [P_W-1:0]   prod);
    logic signed [SUM_W-1:0] sum;
    sum = SUM_W'(acc) + SUM_W'(prod);
    if (sum > SUM_MAX)
      sat_acc = {1'b1, SUM_MAX[ACC_W-1:0]};
    else if (sum < SUM_MIN)
      sat_acc = {1'b1, SUM_MIN[ACC_W-1:0]};
    else
      sat_acc = {1'b0, sum[ACC_W-1:0]};
  endfunction

  logic [1:0]              state;
  logic [SRC_W-1:0]        owner;       // current owner, doubles as last-granted pointer
  logic [LEN_W-1:0]        beats_left;
  logic                    drain_cnt;
  logic                    grant_ok;
  logic [SRC_W-1:0]        grant_idx;
  logic [LEN_W-1:0]        grant_len;
  logic                    start_p0;
  logic                    accept_p0;

  logic                    vld_p1;
  logic signed [A_W-1:0]   a_p1;
  logic signed [B_W-1:0]   b_p1   [N_MAC];

  logic signed [ACC_W-1:0] acc_p2  [N_MAC];
  logic signed [ACC_W-1:0] acc_nxt [N_MAC];
  logic [N_MAC-1:0]        lane_sat;
  logic                    any_sat;
  logic                    ovf_p2;

  // Round-robin search starting one past the last granted client.
  always_comb begin
    grant_ok  = 1'b0;
    grant_idx = owner;
    for (int i = 1; i <= N_SRC; i++) begin
      if (!grant_ok && req[(int'(owner) + i) % N_SRC]) begin
        grant_ok  = 1'b1;
        grant_idx = SRC_W'((int'(owner) + i) % N_SRC);
      end
    end
  end

  assign grant_len = req_len[int'(grant_idx)*LEN_W +: LEN_W];
  assign start_p0  = (state == IDLE) && grant_ok;
  assign accept_p0 = op_valid && (state == RUN);

  // Job control FSM: arbitrate, count accepted beats, drain the pipeline, report.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= SRC_W'(N_SRC - 1);
      beats_left <= '0;
      drain_cnt  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_ok) begin
            state      <= RUN;
            owner      <= grant_idx;
            beats_left <= (grant_len == '0) ? LEN_W'(1) : grant_len;
          end
        end
        RUN: begin
          if (accept_p0) begin
            if (beats_left == LEN_W'(1)) begin
              state     <= DRAIN;
              drain_cnt <= 1'b0;
            end else begin
              beats_left <= beats_left - LEN_W'(1);
            end
          end
        end
        DRAIN: begin
          if (drain_cnt) state <= DONE;
          else           drain_cnt <= 1'b1;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // ---- stage 1: register accepted operands ----
  // Stage-1 valid flag tracks accepted beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p1 <= 1'b0;
    else        vld_p1 <= accept_p0;
  end

  // Stage-1 operand capture.
  always_ff @(posedge clk) begin
    if (accept_p0) begin
      a_p1 <= op_a;
      for (int k = 0; k < N_MAC; k++) b_p1[k] <= op_b[k*B_W +: B_W];
    end
  end

  // ---- stage 2: multiply and saturating accumulate ----
  // Per-lane product and saturated next accumulator value.
  always_comb begin
    any_sat  = 1'b0;
    lane_sat = '0;
    for (int k = 0; k < N_MAC; k++) begin
      {lane_sat[k], acc_nxt[k]} = sat_acc(acc_p2[k], P_W'(a_p1) * P_W'(b_p1[k]));
      any_sat = any_sat | lane_sat[k];
    end
  end

  // Accumulators and sticky overflow: cleared on grant, updated per stage-1 beat, held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_MAC; k++) acc_p2[k] <= '0;
      ovf_p2 <= 1'b0;
    end else if (start_p0) begin
      for (int k = 0; k < N_MAC; k++) acc_p2[k] <= '0;
      ovf_p2 <= 1'b0;
    end else if (vld_p1) begin
      for (int k = 0; k < N_MAC; k++) acc_p2[k] <= acc_nxt[k];
      ovf_p2 <= ovf_p2 | any_sat;
    end
  end

  assign op_ready  = (state == RUN);
  assign busy      = (state != IDLE);
  assign res_valid = (state == DONE);
  assign res_src   = (state == DONE) ? owner : '0;
  assign gnt       = busy ? (N_SRC'(1) << owner) : '0;
  assign res_ovf   = ovf_p2;

  for (genvar k = 0; k < N_MAC; k++) begin : g_res
    assign res_data[k*ACC_W +: ACC_W] = acc_p2[k];
  end

endmodule

// File: tb/tb_shared_mac_array.sv
// Directed bench for shared_mac_array: arbitration, latency, accumulation,
// saturation, bubbles, zero-length jobs and mid-job reset.
module tb_shared_mac_array;
  localparam int N_MAC = 16;
  localparam int N_SRC = 3;
  localparam int A_W   = 16;
  localparam int B_W   = 8;
  localparam int ACC_W = 23;
  localparam int LEN_W = 10;
  localparam int SRC_W = 2;
  localparam int DW    = N_MAC * ACC_W;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b1;
  logic [N_SRC-1:0]       req = '0;
  logic [N_SRC*LEN_W-1:0] req_len = '0;
  logic [N_SRC-1:0]       gnt;
  logic                   op_valid = 1'b0;
  logic [A_W-1:0]         op_a = '0;
  logic [N_MAC*B_W-1:0]   op_b = '0;
  logic                   op_ready;
  logic                   res_valid;
  logic [SRC_W-1:0]       res_src;
  logic [DW-1:0]          res_data;
  logic                   res_ovf;
  logic                   busy;

  int tests = 0;
  int fails = 0;

  shared_mac_array #(
    .N_MAC(N_MAC), .N_SRC(N_SRC), .A_W(A_W), .B_W(B_W), .ACC_W(ACC_W), .LEN_W(LEN_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_len(req_len), .gnt(gnt),
    .op_valid(op_valid), .op_a(op_a), .op_b(op_b), .op_ready(op_ready),
    .res_valid(res_valid), .res_src(res_src), .res_data(res_data),
    .res_ovf(res_ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] vec_uniform(input int e);
    logic [DW-1:0] v;
    v = '0;
    for (int k = 0; k < N_MAC; k++) v[k*ACC_W +: ACC_W] = ACC_W'(e);
    return v;
  endfunction

  function automatic logic [DW-1:0] vec_ramp(input int m);
    logic [DW-1:0] v;
    v = '0;
    for (int k = 0; k < N_MAC; k++) v[k*ACC_W +: ACC_W] = ACC_W'(m * (k - 8));
    return v;
  endfunction

  function automatic logic [N_MAC*B_W-1:0] b_uniform(input int b);
    logic [N_MAC*B_W-1:0] v;
    v = '0;
    for (int k = 0; k < N_MAC; k++) v[k*B_W +: B_W] = B_W'(b);
    return v;
  endfunction

  function automatic logic [N_MAC*B_W-1:0] b_ramp();
    logic [N_MAC*B_W-1:0] v;
    v = '0;
    for (int k = 0; k < N_MAC; k++) v[k*B_W +: B_W] = B_W'(k - 8);
    return v;
  endfunction

  task automatic set_len(input int i, input int l);
    req_len[i*LEN_W +: LEN_W] = LEN_W'(l);
  endtask

  task automatic start_job(input string tag, input logic [N_SRC-1:0] mask, input int src);
    req = mask;
    tick();
    check({tag, "_gnt"}, DW'(gnt), DW'(1 << src));
    check({tag, "_busy"}, DW'(busy), DW'(1));
  endtask

  task automatic send_beat(input string tag, input int a, input logic [N_MAC*B_W-1:0] b);
    check({tag, "_rdy"}, DW'(op_ready), DW'(1));
    op_valid = 1'b1;
    op_a     = A_W'(a);
    op_b     = b;
    tick();
    op_valid = 1'b0;
  endtask

  task automatic bubble(input string tag);
    check({tag, "_rdy_bubble"}, DW'(op_ready), DW'(1));
    tick();
  endtask

  // Called at cycle t+1 after the last beat was accepted at cycle t.
  task automatic expect_result(input string tag, input int src,
                               input logic [DW-1:0] exp_data, input bit exp_ovf);
    check({tag, "_rdy_drop"}, DW'(op_ready), DW'(0));
    check({tag, "_rv_t1"}, DW'(res_valid), DW'(0));
    tick();
    check({tag, "_rv_t2"}, DW'(res_valid), DW'(0));
    tick();
    check({tag, "_rv_t3"}, DW'(res_valid), DW'(1));
    check({tag, "_src"}, DW'(res_src), DW'(src));
    check({tag, "_gnt_done"}, DW'(gnt), DW'(1 << src));
    check({tag, "_data"}, res_data, exp_data);
    check({tag, "_ovf"}, DW'(res_ovf), DW'(exp_ovf));
    tick();
    check({tag, "_rv_end"}, DW'(res_valid), DW'(0));
    check({tag, "_gnt_end"}, DW'(gnt), DW'(0));
    check({tag, "_busy_end"}, DW'(busy), DW'(0));
    check({tag, "_hold"}, res_data, exp_data);
  endtask

  initial begin
    // Reset
    #2 rst_n = 1'b0;
    #1;
    check("rst_gnt", DW'(gnt), DW'(0));
    check("rst_ready", DW'(op_ready), DW'(0));
    check("rst_rv", DW'(res_valid), DW'(0));
    check("rst_busy", DW'(busy), DW'(0));
    check("rst_data", res_data, DW'(0));
    check("rst_ovf", DW'(res_ovf), DW'(0));
    check("rst_src", DW'(res_src), DW'(0));
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Basic job, client 0, req dropped mid-job: 2*5 - 3*5 + 4*5 = 15
    set_len(0, 3);
    start_job("basic", 3'b001, 0);
    req = '0;
    send_beat("basic_b0", 2, b_uniform(5));
    send_beat("basic_b1", -3, b_uniform(5));
    send_beat("basic_b2", 4, b_uniform(5));
    expect_result("basic", 0, vec_uniform(15), 1'b0);

    // op_valid in IDLE is ignored and the result holds
    op_valid = 1'b1; op_a = A_W'(1000); op_b = b_uniform(3);
    tick(); tick(); tick();
    op_valid = 1'b0;
    check("idle_ignore", res_data, vec_uniform(15));
    check("idle_busy", DW'(busy), DW'(0));

    // Zero length acts as one beat; extra op_valid during drain ignored. Lane k = 7*(k-8)
    set_len(1, 0);
    start_job("len0", 3'b010, 1);
    req = '0;
    send_beat("len0_b0", 7, b_ramp());
    op_valid = 1'b1; op_a = A_W'(100); op_b = b_uniform(1);
    expect_result("len0", 1, vec_ramp(7), 1'b0);
    op_valid = 1'b0;

    // Positive saturation: 4 x 32767*127 saturates at 4194303
    set_len(2, 4);
    start_job("satp", 3'b100, 2);
    req = '0;
    for (int i = 0; i < 4; i++) send_beat("satp_b", 32767, b_uniform(127));
    expect_result("satp", 2, vec_uniform(4194303), 1'b1);

    // Negative saturation: 2 x -32768*127 saturates at -4194304
    set_len(2, 2);
    start_job("satn", 3'b100, 2);
    req = '0;
    send_beat("satn_b0", -32768, b_uniform(127));
    send_beat("satn_b1", -32768, b_uniform(127));
    expect_result("satn", 2, vec_uniform(-4194304), 1'b1);

    // Bubbles: 3*11 + (-5)*11 = -22, ovf cleared by the new grant
    set_len(0, 2);
    start_job("bub", 3'b001, 0);
    req = '0;
    send_beat("bub_b0", 3, b_uniform(11));
    bubble("bub1");
    bubble("bub2");
    bubble("bub3");
    send_beat("bub_b1", -5, b_uniform(11));
    expect_result("bub", 0, vec_uniform(-22), 1'b0);

    // Reset after the 2nd of 5 beats
    set_len(0, 5);
    start_job("mrst", 3'b001, 0);
    req = '0;
    send_beat("mrst_b0", 1, b_uniform(1));
    send_beat("mrst_b1", 1, b_uniform(1));
    rst_n = 1'b0;
    #1;
    check("mrst_gnt", DW'(gnt), DW'(0));
    check("mrst_ready", DW'(op_ready), DW'(0));
    check("mrst_rv", DW'(res_valid), DW'(0));
    check("mrst_busy", DW'(busy), DW'(0));
    check("mrst_data", res_data, DW'(0));
    check("mrst_ovf", DW'(res_ovf), DW'(0));
    tick();
    check("mrst_rv_hold1", DW'(res_valid), DW'(0));
    tick();
    check("mrst_rv_hold2", DW'(res_valid), DW'(0));
    rst_n = 1'b1;

    // Round robin with req held: 001, 010, 100; client j gets a=j+1, b=2
    set_len(0, 1);
    set_len(1, 1);
    set_len(2, 1);
    for (int j = 0; j < 3; j++) begin
      start_job("rr", 3'b111, j);
      send_beat("rr_b", j + 1, b_uniform(2));
      expect_result("rr", j, vec_uniform(2 * (j + 1)), 1'b0);
    end
    req = '0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
